csr_unit: RTL and testbench

//  Machine-mode CSR register file with real storage. Sits beside the execute stage.

---
 rtl/csr_unit.sv | 201 ++++++++++++++++++++
 tb/tb_csr_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file: Zicsr ops, trap capture/MRET restore, trap vector and return PC.
// Optional CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters and their user shadows.
module csr_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0,
    parameter logic [XLEN-1:0] HART_ID     = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            csr_valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_address,
    input  logic [XLEN-1:0] rs1,
    input  logic [4:0]      rs1_index,
    output logic [XLEN-1:0] rd,
    output logic            rd_valid,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_value,
    input  logic            mret_valid,
    input  logic            instret_pulse,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mret_pc,
    output logic            global_ie
);

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
`endif

    logic            r_mie, r_mpie;
    logic [XLEN-1:0] r_mie_reg, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
`ifdef CSR_COUNTERS_EN
    logic [2*XLEN-1:0] r_mcycle, r_minstret;
`endif

    logic            w_act, w_f3_bad, w_do_write, w_known, w_ro, w_illegal, w_we;
    logic [XLEN-1:0] w_src, w_old, w_new, w_mstatus, w_base;

    assign w_mstatus  = {{(XLEN-8){1'b0}}, r_mpie, 3'b000, r_mie, 3'b000};
    // Trap and MRET pre-empt any CSR op presented in the same cycle.
    assign w_act      = csr_valid && (opcode == OPC_SYSTEM) && !trap_valid && !mret_valid;
    assign w_f3_bad   = (funct3[1:0] == 2'b00);
    assign w_src      = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_index} : rs1;
    assign w_do_write = (funct3[1:0] == 2'b01) || (rs1_index != 5'd0);
    assign w_ro       = (csr_address == A_MHARTID) || (csr_address[11:8] == 4'hC);
    assign w_illegal  = w_f3_bad || !w_known || (w_ro && w_do_write);
    assign w_we       = w_act && !w_illegal && w_do_write;

    always_comb begin
        w_old   = {XLEN{1'b0}};
        w_known = 1'b1;
        case (csr_address)
            A_MSTATUS:   w_old = w_mstatus;
            A_MIE:       w_old = r_mie_reg;
            A_MTVEC:     w_old = r_mtvec;
            A_MSCRATCH:  w_old = r_mscratch;
            A_MEPC:      w_old = r_mepc;
            A_MCAUSE:    w_old = r_mcause;
            A_MTVAL:     w_old = r_mtval;
            A_MHARTID:   w_old = HART_ID;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE, A_CYCLE:       w_old = r_mcycle[XLEN-1:0];
            A_MCYCLEH, A_CYCLEH:     w_old = r_mcycle[2*XLEN-1:XLEN];
            A_MINSTRET, A_INSTRET:   w_old = r_minstret[XLEN-1:0];
            A_MINSTRETH, A_INSTRETH: w_old = r_minstret[2*XLEN-1:XLEN];
`endif
            default:     w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_new = w_old;
        case (funct3[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = w_old | w_src;
            2'b11:   w_new = w_old & ~w_src;
            default: w_new = w_old;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mie_reg  <= {XLEN{1'b0}};
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= {XLEN{1'b0}};
            r_mepc     <= {XLEN{1'b0}};
            r_mcause   <= {XLEN{1'b0}};
            r_mtval    <= {XLEN{1'b0}};
        end else if (trap_valid) begin
            r_mepc   <= {trap_pc[XLEN-1:2], 2'b00};
            r_mcause <= trap_cause;
            r_mtval  <= trap_value;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (mret_valid) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_we) begin
            case (csr_address)
                A_MSTATUS: begin
                    r_mie  <= w_new[3];
                    r_mpie <= w_new[7];
                end
                A_MIE:      r_mie_reg  <= w_new;
                // Reserved MODE encodings 2/3 collapse to direct mode.
                A_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2], (w_new[1:0] == 2'b01) ? 2'b01 : 2'b00};
                A_MSCRATCH: r_mscratch <= w_new;
                A_MEPC:     r_mepc     <= w_new;
                A_MCAUSE:   r_mcause   <= w_new;
                A_MTVAL:    r_mtval    <= w_new;
                default:    r_mscratch <= r_mscratch;
            endcase
        end else begin
            r_mie <= r_mie;
        end
    end

`ifdef CSR_COUNTERS_EN
    // A write to either half replaces it and skips that counter's increment this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcycle   <= {(2*XLEN){1'b0}};
            r_minstret <= {(2*XLEN){1'b0}};
        end else begin
            if (w_we && (csr_address == A_MCYCLE)) begin
                r_mcycle[XLEN-1:0] <= w_new;
            end else if (w_we && (csr_address == A_MCYCLEH)) begin
                r_mcycle[2*XLEN-1:XLEN] <= w_new;
            end else begin
                r_mcycle <= r_mcycle + {{(2*XLEN-1){1'b0}}, 1'b1};
            end
            if (w_we && (csr_address == A_MINSTRET)) begin
                r_minstret[XLEN-1:0] <= w_new;
            end else if (w_we && (csr_address == A_MINSTRETH)) begin
                r_minstret[2*XLEN-1:XLEN] <= w_new;
            end else if (instret_pulse) begin
                r_minstret <= r_minstret + {{(2*XLEN-1){1'b0}}, 1'b1};
            end else begin
                r_minstret <= r_minstret;
            end
        end
    end
`else
    logic w_unused_instret;
    assign w_unused_instret = instret_pulse;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd          <= {XLEN{1'b0}};
            rd_valid    <= 1'b0;
            csr_illegal <= 1'b0;
        end else begin
            rd_valid    <= w_act && !w_illegal;
            csr_illegal <= w_act && w_illegal;
            if (w_act && !w_illegal) begin
                rd <= w_old;
            end else begin
                rd <= rd;
            end
        end
    end

    assign w_base = {r_mtvec[XLEN-1:2], 2'b00};

    // Vectored mode offsets only interrupts; exceptions always land on BASE.
    always_comb begin
        trap_vector = w_base;
        if ((r_mtvec[1:0] == 2'b01) && trap_cause[XLEN-1]) begin
            trap_vector = w_base + {trap_cause[XLEN-3:0], 2'b00};
        end else begin
            trap_vector = w_base;
        end
    end

    assign mret_pc   = {r_mepc[XLEN-1:2], 2'b00};
    assign global_ie = r_mie;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit; counter checks run when CSR_COUNTERS_EN is defined.
module tb_csr_unit;

    localparam logic [6:0]  SYS  = 7'b1110011;
    localparam logic [31:0] HART = 32'h0000_0003;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        csr_valid = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [11:0] csr_address = 12'd0;
    logic [31:0] rs1 = 32'd0;
    logic [4:0]  rs1_index = 5'd0;
    logic [31:0] rd;
    logic        rd_valid, csr_illegal;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_cause = 32'd0;
    logic [31:0] trap_pc = 32'd0;
    logic [31:0] trap_value = 32'd0;
    logic        mret_valid = 1'b0;
    logic        instret_pulse = 1'b0;
    logic [31:0] trap_vector, mret_pc;
    logic        global_ie;

    int n_total = 0;
    int n_bad   = 0;

    csr_unit #(.XLEN(32), .MTVEC_RESET(32'h0), .HART_ID(HART)) dut (
        .clk(clk), .reset(reset), .csr_valid(csr_valid), .opcode(opcode), .funct3(funct3),
        .csr_address(csr_address), .rs1(rs1), .rs1_index(rs1_index), .rd(rd),
        .rd_valid(rd_valid), .csr_illegal(csr_illegal), .trap_valid(trap_valid),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_value(trap_value),
        .mret_valid(mret_valid), .instret_pulse(instret_pulse), .trap_vector(trap_vector),
        .mret_pc(mret_pc), .global_ie(global_ie)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one op for exactly one rising edge, then sample 1 ns later.
    task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] v,
                         input logic [4:0] idx);
        @(negedge clk);
        csr_valid = 1'b1; opcode = SYS; funct3 = f3; csr_address = a; rs1 = v; rs1_index = idx;
        @(posedge clk); #1;
        csr_valid = 1'b0;
    endtask

    task automatic read_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        do_op(3'b010, a, 32'hFFFF_FFFF, 5'd0);
        check_val({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
        check_val(tag, rd, exp);
    endtask

    initial begin
        #12;
        check_val("rst_rd", rd, 32'd0);
        check_val("rst_vld", {31'd0, rd_valid}, 32'd0);
        check_val("rst_ill", {31'd0, csr_illegal}, 32'd0);
        check_val("rst_ie", {31'd0, global_ie}, 32'd0);
        check_val("rst_vec", trap_vector, 32'd0);
        @(negedge clk); reset = 1'b1;

        do_op(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5);
        check_val("rw_vld", {31'd0, rd_valid}, 32'd1);
        check_val("rw_old", rd, 32'd0);
        read_csr("rs0_a", 12'h340, 32'hDEAD_BEEF);
        read_csr("rs0_b", 12'h340, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check_val("rd_hold", rd, 32'hDEAD_BEEF);
        check_val("vld_pulse", {31'd0, rd_valid}, 32'd0);

        do_op(3'b110, 12'h300, 32'd0, 5'd8);
        check_val("rsi_ie", {31'd0, global_ie}, 32'd1);
        do_op(3'b111, 12'h300, 32'd0, 5'd8);
        check_val("rci_old", rd, 32'h8);
        check_val("rci_ie", {31'd0, global_ie}, 32'd0);
        do_op(3'b110, 12'h300, 32'd0, 5'd0);
        check_val("rsi0_ie", {31'd0, global_ie}, 32'd0);
        do_op(3'b110, 12'h300, 32'd0, 5'd8);

        do_op(3'b001, 12'h305, 32'h0000_1001, 5'd1);
        @(negedge clk);
        trap_cause = 32'h8000_0007; #1;
        check_val("vec_int", trap_vector, 32'h0000_101C);
        trap_cause = 32'h0000_0007; #1;
        check_val("vec_exc", trap_vector, 32'h0000_1000);
        trap_cause = 32'h8000_0007; trap_pc = 32'h107; trap_value = 32'h55; trap_valid = 1'b1;
        @(posedge clk); #1;
        trap_valid = 1'b0;
        check_val("trap_ie", {31'd0, global_ie}, 32'd0);
        check_val("trap_mretpc", mret_pc, 32'h104);
        read_csr("trap_mepc", 12'h341, 32'h104);
        read_csr("trap_mcause", 12'h342, 32'h8000_0007);
        read_csr("trap_mtval", 12'h343, 32'h55);
        read_csr("trap_mstatus", 12'h300, 32'h80);

        @(negedge clk); mret_valid = 1'b1;
        @(posedge clk); #1; mret_valid = 1'b0;
        check_val("mret_ie", {31'd0, global_ie}, 32'd1);
        check_val("mret_pc", mret_pc, 32'h104);
        read_csr("mret_mstatus", 12'h300, 32'h88);

        @(negedge clk);
        csr_valid = 1'b1; opcode = SYS; funct3 = 3'b001; csr_address = 12'h341;
        rs1 = 32'hAAAA_0000; rs1_index = 5'd3;
        trap_valid = 1'b1; trap_pc = 32'h200; trap_cause = 32'h2; trap_value = 32'h0;
        @(posedge clk); #1;
        csr_valid = 1'b0; trap_valid = 1'b0;
        check_val("tw_vld", {31'd0, rd_valid}, 32'd0);
        check_val("tw_ill", {31'd0, csr_illegal}, 32'd0);
        read_csr("tw_mepc", 12'h341, 32'h200);

        do_op(3'b001, 12'hF14, 32'h1, 5'd1);
        check_val("hart_w_ill", {31'd0, csr_illegal}, 32'd1);
        check_val("hart_w_vld", {31'd0, rd_valid}, 32'd0);
        read_csr("hart_rd", 12'hF14, HART);
        check_val("hart_r_ill", {31'd0, csr_illegal}, 32'd0);
        do_op(3'b100, 12'h340, 32'h0, 5'd0);
        check_val("f3_ill", {31'd0, csr_illegal}, 32'd1);
        do_op(3'b010, 12'h7C0, 32'h0, 5'd0);
        check_val("addr_ill", {31'd0, csr_illegal}, 32'd1);

        @(negedge clk);
        csr_valid = 1'b1; opcode = 7'b0110011; funct3 = 3'b001; csr_address = 12'h340;
        rs1 = 32'h1; rs1_index = 5'd1;
        @(posedge clk); #1; csr_valid = 1'b0;
        check_val("badopc_vld", {31'd0, rd_valid}, 32'd0);
        check_val("badopc_ill", {31'd0, csr_illegal}, 32'd0);
        read_csr("badopc_keep", 12'h340, 32'hDEAD_BEEF);

        do_op(3'b001, 12'h305, 32'h0000_1003, 5'd1);
        read_csr("mtvec_mode3", 12'h305, 32'h0000_1000);
        trap_cause = 32'h8000_0007; #1;
        check_val("vec_direct", trap_vector, 32'h0000_1000);

        do_op(3'b001, 12'h300, 32'hFFFF_FFFF, 5'd1);
        check_val("ms_old", rd, 32'h80);
        read_csr("ms_mask", 12'h300, 32'h88);

`ifdef CSR_COUNTERS_EN
        do_op(3'b001, 12'hB00, 32'hFFFF_FFFF, 5'd1);
        @(posedge clk);
        read_csr("mcycleh_carry", 12'hB80, 32'h1);
        do_op(3'b001, 12'hC00, 32'h0, 5'd1);
        check_val("cycle_ro_ill", {31'd0, csr_illegal}, 32'd1);
`else
        do_op(3'b010, 12'hB00, 32'h0, 5'd0);
        check_val("nocnt_ill", {31'd0, csr_illegal}, 32'd1);
`endif

        do_op(3'b010, 12'h340, 32'h0, 5'd0);
        reset = 1'b0; #1;
        check_val("arst_vld", {31'd0, rd_valid}, 32'd0);
        check_val("arst_rd", rd, 32'd0);
        check_val("arst_ie", {31'd0, global_ie}, 32'd0);
        @(negedge clk); reset = 1'b1;
        read_csr("arst_mscratch", 12'h340, 32'd0);

`ifdef CSR_COUNTERS_EN
        read_csr("arst_mcycleh", 12'hB80, 32'd0);
        @(negedge clk); instret_pulse = 1'b1;
        repeat (3) @(posedge clk);
        #1; instret_pulse = 1'b0;
        read_csr("instret_cnt", 12'hC02, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
